// File: rtl/carfield_clk_seq.sv
// Clock-domain reconfiguration sequencer: gates a domain, writes its PLL divider,
// waits for a stable lock (or times out), then ungates and reports completion.
module carfield_clk_seq #(
    parameter int unsigned         NumClks      = 3,
    parameter int unsigned         DivWidth     = 8,
    parameter int unsigned         GateCycles   = 2,
    parameter int unsigned         StableCycles = 16,
    parameter int unsigned         LockTimeout  = 1024,
    parameter logic [NumClks-1:0]  ClkEnRst     = '1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_idx_i,
    input  logic [DivWidth-1:0] req_div_i,
    output logic                pll_cfg_valid_o,
    input  logic                pll_cfg_ready_i,
    output logic [1:0]          pll_cfg_idx_o,
    output logic [DivWidth-1:0] pll_cfg_div_o,
    input  logic [NumClks-1:0]  pll_lock_i,
    output logic [NumClks-1:0]  clk_en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                done_err_o,
    output logic [NumClks-1:0]  err_o,
    input  logic                err_clr_i
);

    localparam int unsigned GW  = $clog2(GateCycles) + 1;
    localparam int unsigned StW = $clog2(StableCycles) + 1;
    localparam int unsigned ToW = $clog2(LockTimeout) + 1;
    localparam logic [GW-1:0]  GateMax = GW'(GateCycles);
    localparam logic [StW-1:0] StMax   = StW'(StableCycles);
    localparam logic [ToW-1:0] ToMax   = ToW'(LockTimeout);

    typedef enum logic [2:0] {
        IDLE, GATE, CFG, WAIT_LOCK, UNGATE, ERR
    } state_e;

    state_e                state_q;
    logic [1:0]            idx_q;
    logic [DivWidth-1:0]   div_q;
    logic [GW-1:0]         gate_q;
    logic [StW-1:0]        stable_q, stable_d;
    logic [ToW-1:0]        timeout_q, timeout_d;
    logic [NumClks-1:0]    clk_en_q, err_q;
    logic                  cfg_valid_q, done_q, done_err_q;
    logic                  idx_valid, lock_sel;

    // Indices beyond the implemented domains must never touch a PLL or a gate.
    always_comb begin
        idx_valid = (32'(idx_q) < NumClks);
        lock_sel  = 1'b0;
        if (idx_valid) lock_sel = pll_lock_i[idx_q];
        stable_d  = lock_sel ? (stable_q + StW'(1)) : '0;
        timeout_d = timeout_q + ToW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            div_q       <= '0;
            gate_q      <= '0;
            stable_q    <= '0;
            timeout_q   <= '0;
            clk_en_q    <= ClkEnRst;
            err_q       <= '0;
            cfg_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            // The ERR branch below is written later, so a same-cycle set beats the clear.
            if (err_clr_i) err_q <= '0;
            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        idx_q   <= req_idx_i;
                        div_q   <= req_div_i;
                        gate_q  <= '0;
                        state_q <= GATE;
                    end
                end
                GATE: begin
                    if (!idx_valid) begin
                        done_q     <= 1'b1;
                        done_err_q <= 1'b1;
                        state_q    <= IDLE;
                    end else begin
                        clk_en_q[idx_q] <= 1'b0;
                        if (gate_q == GateMax) begin
                            cfg_valid_q <= 1'b1;
                            state_q     <= CFG;
                        end else begin
                            gate_q <= gate_q + GW'(1);
                        end
                    end
                end
                CFG: begin
                    if (pll_cfg_ready_i) begin
                        cfg_valid_q <= 1'b0;
                        stable_q    <= '0;
                        timeout_q   <= '0;
                        state_q     <= WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    stable_q  <= stable_d;
                    timeout_q <= timeout_d;
                    // Success is checked first so a tie with the timeout still ungates.
                    if (stable_d == StMax) begin
                        state_q <= UNGATE;
                    end else if (timeout_d == ToMax) begin
                        state_q <= ERR;
                    end
                end
                UNGATE: begin
                    clk_en_q[idx_q] <= 1'b1;
                    done_q          <= 1'b1;
                    state_q         <= IDLE;
                end
                ERR: begin
                    err_q[idx_q] <= 1'b1;
                    done_q       <= 1'b1;
                    done_err_q   <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o     = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign pll_cfg_valid_o = cfg_valid_q;
    assign pll_cfg_idx_o   = idx_q;
    assign pll_cfg_div_o   = div_q;
    assign clk_en_o        = clk_en_q;
    assign err_o           = err_q;
    assign done_o          = done_q;
    assign done_err_o      = done_err_q;

endmodule

// File: tb/tb_carfield_clk_seq.sv
// Directed bench for carfield_clk_seq: stimulus pushes the expected completion
// record into a queue and a negedge monitor checks every done_o pulse against it.
module tb_carfield_clk_seq;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [1:0] req_idx_i = '0;
    logic [7:0] req_div_i = '0;
    logic       pll_cfg_valid_o;
    logic       pll_cfg_ready_i = 1'b1;
    logic [1:0] pll_cfg_idx_o;
    logic [7:0] pll_cfg_div_o;
    logic [2:0] pll_lock_i = 3'b111;
    logic [2:0] clk_en_o;
    logic       busy_o, done_o, done_err_o;
    logic [2:0] err_o;
    logic       err_clr_i = 1'b0;

    typedef struct {
        logic       err;
        logic [2:0] clkEn;
        logic [2:0] errO;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    carfield_clk_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_idx_i(req_idx_i), .req_div_i(req_div_i),
        .pll_cfg_valid_o(pll_cfg_valid_o), .pll_cfg_ready_i(pll_cfg_ready_i),
        .pll_cfg_idx_o(pll_cfg_idx_o), .pll_cfg_div_o(pll_cfg_div_o),
        .pll_lock_i(pll_lock_i), .clk_en_o(clk_en_o),
        .busy_o(busy_o), .done_o(done_o), .done_err_o(done_err_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
    endtask

    // Issue one request; on return we sit at the negedge right after acceptance (cyc=0).
    task automatic applyStimulus(input logic [1:0] idx, input logic [7:0] div);
        req_valid_i = 1'b1;
        req_idx_i   = idx;
        req_div_i   = div;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cyc = 0;
    endtask

    task automatic waitDone(input string name, input int expCyc);
        while (!done_o && cyc < expCyc + 5) step();
        checkOutput(name, cyc, expCyc);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (rst_ni && done_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected done_o", 32'(done_o), 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("done_err_o", 32'(done_err_o), 32'(e.err));
                checkOutput("clk_en_o at done", 32'(clk_en_o), 32'(e.clkEn));
                checkOutput("err_o at done", 32'(err_o), 32'(e.errO));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("reset clk_en_o", 32'(clk_en_o), 32'h7);
        checkOutput("reset err_o", 32'(err_o), 32'h0);
        checkOutput("reset busy_o", 32'(busy_o), 32'h0);
        checkOutput("reset req_ready_o", 32'(req_ready_o), 32'h1);
        checkOutput("reset cfg_valid", 32'(pll_cfg_valid_o), 32'h0);

        // Nominal reconfiguration of periph domain, lock already high.
        expQ.push_back('{err: 1'b0, clkEn: 3'b111, errO: 3'b000});
        applyStimulus(2'd1, 8'h10);
        checkOutput("t1 busy", 32'(busy_o), 32'h1);
        checkOutput("t1 ready", 32'(req_ready_o), 32'h0);
        step();
        checkOutput("t1 gated clk_en", 32'(clk_en_o), 32'h5);
        step();
        checkOutput("t1 cfg_valid early", 32'(pll_cfg_valid_o), 32'h0);
        step();
        checkOutput("t1 cfg_valid", 32'(pll_cfg_valid_o), 32'h1);
        checkOutput("t1 cfg_idx", 32'(pll_cfg_idx_o), 32'h1);
        checkOutput("t1 cfg_div", 32'(pll_cfg_div_o), 32'h10);
        waitDone("t1 done cycle", 21);
        step();
        checkOutput("t1 idle", 32'(busy_o), 32'h0);

        // Lock glitches low after ten stable cycles; the count must restart.
        expQ.push_back('{err: 1'b0, clkEn: 3'b111, errO: 3'b000});
        applyStimulus(2'd2, 8'h33);
        while (cyc < 14) step();
        checkOutput("t2 gated clk_en", 32'(clk_en_o), 32'h3);
        pll_lock_i[2] = 1'b0;
        step();
        pll_lock_i[2] = 1'b1;
        waitDone("t2 done cycle", 32);
        step();

        // Out-of-range index: immediate error completion, no PLL traffic.
        expQ.push_back('{err: 1'b1, clkEn: 3'b111, errO: 3'b000});
        applyStimulus(2'd3, 8'h44);
        step();
        checkOutput("t3 no cfg_valid", 32'(pll_cfg_valid_o), 32'h0);
        waitDone("t3 done cycle", 1);
        step();

        // Host lock never arrives: timeout, with a clear colliding with the error set.
        pll_lock_i[0] = 1'b0;
        expQ.push_back('{err: 1'b1, clkEn: 3'b110, errO: 3'b001});
        applyStimulus(2'd0, 8'h07);
        while (cyc < 1028) step();
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        waitDone("t4 done cycle", 1029);
        step();
        checkOutput("t4 sticky err_o", 32'(err_o), 32'h1);
        checkOutput("t4 clk_en stays off", 32'(clk_en_o), 32'h6);
        err_clr_i = 1'b1;
        step();
        err_clr_i = 1'b0;
        checkOutput("t4 err cleared", 32'(err_o), 32'h0);
        pll_lock_i[0] = 1'b1;

        // Stalled configuration write, then reset mid-CFG abandons the sequence.
        pll_cfg_ready_i = 1'b0;
        applyStimulus(2'd1, 8'hA5);
        step();
        checkOutput("t5 only idx bit gated", 32'(clk_en_o), 32'h4);
        step();
        step();
        begin
            int bad = 0;
            for (int i = 0; i < 50; i++) begin
                if (pll_cfg_valid_o !== 1'b1 || pll_cfg_idx_o !== 2'd1 || pll_cfg_div_o !== 8'hA5) bad++;
                step();
            end
            checkOutput("t5 cfg stable cycles bad", 32'(bad), 32'h0);
        end
        rst_ni = 1'b0;
        #1;
        checkOutput("t5 rst clk_en", 32'(clk_en_o), 32'h7);
        checkOutput("t5 rst cfg_valid", 32'(pll_cfg_valid_o), 32'h0);
        checkOutput("t5 rst busy", 32'(busy_o), 32'h0);
        checkOutput("t5 rst cfg_idx/div", {22'd0, pll_cfg_idx_o, pll_cfg_div_o}, 32'h0);
        checkOutput("t5 rst done", {30'd0, done_o, done_err_o}, 32'h0);
        pll_cfg_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (10) @(negedge clk_i);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/carfield_clk_seq.md
CARFIELD_CLK_SEQ -- requirements
Module: carfield_clk_seq

Interface
REQ-001 SHALL have parameter NumClks, default 3, number of clock domains (index 0 host, 1 periph, 2 alt).
REQ-002 SHALL have parameter DivWidth, default 8, width of the PLL divider field.
REQ-003 SHALL have parameter GateCycles, default 2, cycles the domain stays gated before the PLL is reconfigured.
REQ-004 SHALL have parameter StableCycles, default 16, consecutive lock-high cycles required before ungating.
REQ-005 SHALL have parameter LockTimeout, default 1024, maximum WAIT_LOCK cycles before an error is raised.
REQ-006 SHALL have parameter ClkEnRst, NumClks bits, default all ones, reset value of clk_en_o.
REQ-007 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-008 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port req_valid_i, input, 1, reconfiguration request valid.
REQ-010 SHALL have port req_ready_o, output, 1, request accepted when req_valid_i is also high.
REQ-011 SHALL have port req_idx_i, input, 2, target domain index.
REQ-012 SHALL have port req_div_i, input, DivWidth, requested divider.
REQ-013 SHALL have port pll_cfg_valid_o, input-side handshake out, 1, configuration write valid.
REQ-014 SHALL have port pll_cfg_ready_i, input, 1, PLL accepts the configuration write.
REQ-015 SHALL have ports pll_cfg_idx_o (2) and pll_cfg_div_o (DivWidth), outputs, latched index and divider.
REQ-016 SHALL have port pll_lock_i, input, NumClks, per-domain PLL lock, already synchronised to clk_i.
REQ-017 SHALL have port clk_en_o, output, NumClks, per-domain clock gate enable.
REQ-018 SHALL have ports busy_o (1), done_o (1, pulse), done_err_o (1, valid with done_o), outputs.
REQ-019 SHALL have ports err_o (NumClks, sticky per-domain lock error), output, and err_clr_i (1), input.

Function
REQ-020 SHALL implement states IDLE, GATE, CFG, WAIT_LOCK, UNGATE, ERR; req_ready_o high only in IDLE; busy_o high in all other states.
REQ-021 SHALL latch req_idx_i and req_div_i on acceptance (valid and ready at edge T0) and move to GATE.
REQ-022 SHALL, for req_idx_i >= NumClks, skip all PLL action, return to IDLE, and pulse done_o with done_err_o=1 at T0+1; clk_en_o and err_o unchanged.
REQ-023 SHALL clear clk_en_o[idx] from T0+1 and remain in GATE for exactly GateCycles cycles, then enter CFG.
REQ-024 SHALL hold pll_cfg_valid_o high in CFG, with pll_cfg_idx_o/pll_cfg_div_o stable, until pll_cfg_ready_i; pll_cfg_valid_o SHALL be 0 in all other states.
REQ-025 SHALL enter WAIT_LOCK on the cycle after the cfg handshake, clearing the stable counter and timeout counter.
REQ-026 SHALL increment the stable counter each cycle pll_lock_i[idx]=1 and reset it to 0 on any cycle it is 0.
REQ-027 SHALL go to UNGATE when the stable counter reaches StableCycles; if that coincides with the timeout counter reaching LockTimeout, success SHALL win.
REQ-028 SHALL go to ERR when the timeout counter reaches LockTimeout without success.
REQ-029 SHALL in UNGATE set clk_en_o[idx]=1 on exit and pulse done_o with done_err_o=0 in the same cycle clk_en_o rises, returning to IDLE.
REQ-030 SHALL in ERR set err_o[idx]=1, keep clk_en_o[idx]=0, pulse done_o with done_err_o=1 for one cycle, return to IDLE.
REQ-031 SHALL clear all err_o bits on err_clr_i in any state; a same-cycle ERR set SHALL take priority over clear for that bit.
REQ-032 SHALL never modify clk_en_o bits other than the latched index.
REQ-033 SHALL keep counters saturating-free by sizing them to $clog2(max)+1 bits; no wrap-around.

Reset
REQ-034 SHALL on rst_ni low asynchronously force state IDLE, clk_en_o=ClkEnRst, err_o=0, counters 0, pll_cfg_valid_o=0, done_o=0, done_err_o=0, busy_o=0, pll_cfg_idx_o=0, pll_cfg_div_o=0.
REQ-035 SHALL, on reset mid-operation, abandon the sequence with no done_o pulse; clk_en_o returns to ClkEnRst.

Verification
REQ-036 Request idx=1 div=0x10, cfg_ready immediate, lock high -> clk_en_o=3'b101 from T0+1, cfg_valid at T0+3, done_o with done_err_o=0 and clk_en_o=3'b111 after 16 lock cycles.
REQ-037 Request idx=2, lock toggles low at stable count 10 then stays high -> counter restarts, ungate after 16 further consecutive high cycles.
REQ-038 Request idx=0, lock never high -> ERR after 1024 WAIT_LOCK cycles, err_o=3'b001, clk_en_o[0]=0, done_err_o=1; err_clr_i -> err_o=0.
REQ-039 Request idx=3 -> no cfg_valid, done_o and done_err_o at T0+1, clk_en_o=3'b111 unchanged.
REQ-040 cfg_ready held low 50 cycles -> cfg_valid, idx, div stable throughout; rst_ni low mid-CFG -> all outputs at reset values, no done_o.
